// File: rtl/mem_wr_mon_pkg.sv
// mem_wr_mon_pkg
// Shared types and widths for the data-memory write monitor.
//   mon_event_t : one captured write (addr, data, pc)
//   wr_state_t  : edge-detect FSM states
// Optional feature macro used by the users of this package: MEM_WR_MONITOR_PC_EN
package mem_wr_mon_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int PC_W   = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
    } mon_event_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } wr_state_t;

endpackage

// File: rtl/mem_wr_mon_fifo.sv
// mem_wr_mon_fifo
// Synchronous capture FIFO for the write monitor. Registered storage with a
// combinational head read; no write-to-read bypass, so a push into an empty
// FIFO is visible one cycle later.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (pointers cleared)
//   i_push     : write i_din this cycle
//   i_pop      : advance the head this cycle (ignored when empty)
//   i_din      : entry to store
//   o_dout     : head entry, forced to 0 while empty
//   o_empty    : no entries stored
//   o_full     : DEPTH entries stored
//   o_dropped  : push refused because the FIFO was full and not popping
// Macro: none (entry width is set by the parent through W)
module mem_wr_mon_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 62
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_dropped
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_push;
    logic         w_do_pop;

    // Pointers carry one extra wrap bit: equal = empty, only wrap bit differs = full.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dropped = i_push && o_full && !w_do_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

    assign o_dout = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/mem_wr_monitor.sv
// mem_wr_monitor
// Watches the processor data-memory write port and turns each wen burst
// (wen stays high across D-cache stalls) into a single event, queued in a
// small FIFO for a downstream consumer. Also counts cycles since reset until
// the checker reports done.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   addr, data, wen, PC : write port being monitored
//   done                : freezes the duration counter
//   ev_valid, ev_ready  : event handshake (pop on valid && ready)
//   ev_addr/data/pc     : head event fields (0 while empty)
//   duration            : saturating cycle count since reset release
//   overflow            : sticky, an event was dropped on a full FIFO
// Macro: MEM_WR_MONITOR_PC_EN -- store PC per entry; otherwise ev_pc is 0.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no write in progress; wen=1 here captures a new event
// ST_HELD | inside a wen burst; wait for wen=0 before the next capture
module mem_wr_monitor
    import mem_wr_mon_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DUR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [29:0]       addr,
    input  logic [31:0]       data,
    input  logic              wen,
    input  logic [31:0]       PC,
    input  logic              done,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [29:0]       ev_addr,
    output logic [31:0]       ev_data,
    output logic [31:0]       ev_pc,
    output logic [DUR_W-1:0]  duration,
    output logic              overflow
);

`ifdef MEM_WR_MONITOR_PC_EN
    localparam int ENTRY_W = ADDR_W + DATA_W + PC_W;
`else
    localparam int ENTRY_W = ADDR_W + DATA_W;
`endif

    wr_state_t          r_state;
    wr_state_t          w_state_nxt;
    logic               w_capture;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;
    logic               w_dropped;
    logic [ENTRY_W-1:0] w_din;
    logic [ENTRY_W-1:0] w_dout;
    logic [DUR_W-1:0]   r_duration;
    logic               r_overflow;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wen) begin
                    w_state_nxt = ST_HELD;
                    w_capture   = 1'b1;
                end
            end
            ST_HELD: begin
                if (!wen) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef MEM_WR_MONITOR_PC_EN
    assign w_din = {addr, data, PC};
    assign ev_pc = w_dout[PC_W-1:0];
`else
    logic w_unused_pc;
    assign w_unused_pc = ^PC;
    assign w_din = {addr, data};
    assign ev_pc = '0;
`endif

    assign ev_addr = w_dout[ENTRY_W-1 -: ADDR_W];
    assign ev_data = w_dout[ENTRY_W-ADDR_W-1 -: DATA_W];

    assign ev_valid = !w_empty;
    assign w_pop    = ev_valid && ev_ready;

    mem_wr_mon_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_capture),
        .i_pop     (w_pop),
        .i_din     (w_din),
        .o_dout    (w_dout),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_dropped (w_dropped)
    );

    // Full is only informative here; the FIFO already decides drops.
    logic w_unused_full;
    assign w_unused_full = w_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_duration <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (!done && (r_duration != '1))
                r_duration <= r_duration + DUR_W'(1);
            if (w_dropped)
                r_overflow <= 1'b1;
        end
    end

    assign duration = r_duration;
    assign overflow = r_overflow;

endmodule

// File: doc/mem_wr_monitor.md
MEM_WR_MONITOR -- requirements
Module: mem_wr_monitor

Interface
REQ-001 Parameter DEPTH, default 4; capture-FIFO entries, power of two, 2..16.
REQ-002 Parameter DUR_W, default 16; duration counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 addr  input  30  word address of the processor data-memory write port.
REQ-006 data  input  32  write data.
REQ-007 wen  input  1  write enable; held high for several cycles while the D-cache stalls.
REQ-008 PC  input  32  program counter sampled alongside the write.
REQ-009 done  input  1  checker finished; freezes the duration counter.
REQ-010 ev_valid  output  1  a captured write event is available.
REQ-011 ev_ready  input  1  consumer accepts the event.
REQ-012 ev_addr / ev_data / ev_pc  output  30/32/32  head event fields.
REQ-013 duration  output  DUR_W  cycles counted since reset release.
REQ-014 overflow  output  1  sticky; an event was dropped because the FIFO was full.

Function
REQ-015 Edge FSM with two states, IDLE and HELD; IDLE->HELD when wen=1; HELD->IDLE when wen=0; all other cases hold the current state.
REQ-016 A write event is generated exactly once per wen burst, in the cycle where the FSM is IDLE and wen=1, capturing addr, data and PC of that cycle.
REQ-017 Back-to-back bursts separated by one cycle of wen=0 produce two events.
REQ-018 Events are pushed into a DEPTH-entry FIFO; ev_valid=1 whenever the FIFO is non-empty; ev_* shows the head entry.
REQ-019 A pop occurs when ev_valid&&ev_ready; the head advances on the next edge.
REQ-020 A push into a full FIFO with no simultaneous pop drops the new event and sets overflow; contents are unchanged.
REQ-021 A simultaneous push and pop on a full FIFO succeeds; occupancy is unchanged and overflow is not set.
REQ-022 A simultaneous push and pop on an empty FIFO does not bypass; the event appears at ev_valid the next cycle.
REQ-023 Latency from capture cycle to ev_valid=1 is 1 cycle.
REQ-024 Read/write pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty are derived from the MSB compare.
REQ-025 duration increments by 1 each cycle while done=0, saturates at all-ones, and holds once done=1.
REQ-026 ev_* fields are held stable while ev_valid=1 and ev_ready=0.

Reset
REQ-027 On rst=1 at a clock edge: FSM goes to IDLE, pointers to 0, ev_valid=0, overflow=0, duration=0; ev_* data fields are don't-care but SHALL read 0.
REQ-028 Reset mid-burst (wen held high through reset release) SHALL generate an event in the first cycle after release.
REQ-029 FIFO contents are discarded on reset.

Configuration
REQ-030 Macro MEM_WR_MONITOR_PC_EN: defined -> the PC field is stored per entry and driven on ev_pc.
REQ-031 MEM_WR_MONITOR_PC_EN undefined -> no PC storage; ev_pc is tied to 0; all other behaviour is identical.

Structure
REQ-032 Package mem_wr_mon_pkg holds: the event record typedef (addr, data, pc), ADDR_W=30, DATA_W=32, PC_W=32, and the FSM state enum.
REQ-033 One sub-module, mem_wr_mon_fifo (parameterised synchronous FIFO), is instantiated once; the edge FSM and duration counter live in the top level.

Verification
REQ-034 A bench SHALL drive wen=1 for 5 cycles with addr=0, data=0 and check exactly one event {0,0} and ev_valid rising 1 cycle after the first wen cycle.
REQ-035 A bench SHALL drive bursts (addr=4, data=0x11), one idle cycle, then (addr=8, data=0x22) with ev_ready=1, and check two events in order.
REQ-036 With DEPTH=4 and ev_ready=0, a bench SHALL drive 5 single-cycle bursts and check 4 stored events, overflow=1, and first-in data intact.
REQ-037 On a full FIFO with ev_ready=1 and a new burst in the same cycle, a bench SHALL check that occupancy stays 4 and overflow stays 0.
REQ-038 With DUR_W=4 and done=0 for 20 cycles, a bench SHALL check duration=15; after done=1, duration SHALL hold.
REQ-039 A bench SHALL assert rst for 1 cycle while wen=1 and 2 entries are queued, and check ev_valid=0 immediately after reset, followed by one new event on the next cycle.
